serial_byte_tx: RTL and testbench
=================================

Name: serial_byte_tx

Overview:
- Upstream neighbour of the deserializer/queue top; turns parallel bytes into the bit-serial stream that top consumes.
- Drives the top's `data_in`/`write_in` inputs, one strobe per bit, LSB first.
- Starts a byte only after the deserializer's `status_out` has asserted.
- Accepts bytes from a producer through a valid/ready handshake; holds one byte in flight, no internal FIFO.

Parameters:
- WIDTH, 8, bits per word, sent LSB first.
- PRE_CYCLES, 10, cycles `data_out` shows bit 0 before the first strobe.
- HOLD_CYCLES, 10, cycles `write_out` stays high per bit.
- GAP_CYCLES, 10, cycles `write_out` stays low after each strobe.

Ports:
- clock  in  1  single system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- byte_in  in  WIDTH  word to transmit.
- byte_valid_in  in  1  producer offers `byte_in`.
- byte_ready_out  out  1  block can accept a word; transfer when valid && ready.
- status_in  in  1  deserializer ready (connects to top's `status_out`).
- data_out  out  1  serial bit (connects to top's `data_in`).
- write_out  out  1  bit strobe (connects to top's `write_in`).
- busy_out  out  1  high from accept until word complete.
- done_out  out  1  one-cycle pulse when last GAP ends.

Behaviour:
- Reset values:
  - `byte_ready_out`=0 while reset is asserted; 1 in the first cycle after release.
  - `data_out`=0, `write_out`=0, `busy_out`=0, `done_out`=0.
  - Shift register, counters and `armed` flag: `armed`=1, everything else 0.
- States: IDLE, WAIT_RDY, PRE, STROBE, GAP.
- IDLE:
  - `byte_ready_out`=1.
  - On valid && ready: capture `byte_in` into shift register, bit count=0, set `busy_out`, go to WAIT_RDY.
- WAIT_RDY:
  - `byte_ready_out`=0.
  - Leave when `status_in`=1 && `armed`=1: clear `armed`, set `data_out`=bit0, load PRE counter, go to PRE.
- armed flag:
  - Set at reset and on any cycle `status_in`=0.
  - Effect: each word needs a fresh status high period after the previous one.
  - A status that is still high from the previous word does not start a new one.
- PRE: count PRE_CYCLES, then `write_out`=1 and go to STROBE.
- STROBE:
  - `write_out` high for exactly HOLD_CYCLES cycles; `data_out` stable throughout.
  - Then `write_out`=0, shift right, bit count+1, go to GAP.
  - On GAP entry, `data_out` = next bit, or 0 after the last bit.
- GAP: count GAP_CYCLES, then:
  - if bit count < WIDTH: `write_out`=1, go to STROBE.
  - if bit count == WIDTH: `done_out`=1 for one cycle, `busy_out`=0, go to IDLE.
- Data setup: `data_out` changes only when `write_out` falls (or on PRE entry), so it is stable ≥GAP_CYCLES before every strobe.
- Latency: word length is PRE + WIDTH*(HOLD+GAP) cycles from leaving WAIT_RDY to `done_out`; 170 cycles at defaults.
- `status_in` dropping mid-word is ignored; the word always completes. `status_in` is only checked in WAIT_RDY.
- `byte_valid_in` while busy: not accepted (`byte_ready_out`=0); producer holds it.
- Back-to-back: a new word can be accepted in the cycle after `done_out` (IDLE with `byte_ready_out`=1).
- Reset mid-word: outputs go to reset values immediately (asynchronous); the partial word is lost; the deserializer-side recovery belongs to the top's own reset.
- Counters:
  - cycle counter width `$clog2(max(PRE,HOLD,GAP)+1)`, bit counter `$clog2(WIDTH+1)`.
  - Both counters are plain unsigned with no wrap.
  - Any parameter value of 0 is illegal; flag it with an elaboration assertion.

Decomposition:
- `serial_tx_pkg`: state enum typedef (IDLE, WAIT_RDY, PRE, STROBE, GAP) and default timing constants, shared with the bench.
- No sub-module; a single module with one FSM, one down-counter and a shift register.

Test Plan:
- Reset then `byte_in`=0x99, `status_in` high → `data_out` samples at each `write_out` rise = 1,0,0,1,1,0,0,1; exactly 8 strobes, each 10 cycles; `done_out` 170 cycles after PRE entry.
- Offer 0xF0 with `status_in`=0 for 50 cycles → stays in WAIT_RDY with `write_out`=0; after status rises, bits 0,0,0,0,1,1,1,1 are sent.
- After 0x99 completes, offer 0xF0 immediately while `status_in` stays high → no strobe until `status_in` goes low then high again.
- `byte_valid_in` held during transmission with 0x55 → `byte_ready_out`=0 until the cycle after `done_out`; 0x55 is then sent intact.
- Drop `status_in` after bit 3 → the remaining bits are still sent; `done_out` fires at the normal cycle.
- Assert `reset` mid-STROBE of bit 5 → `write_out`/`data_out`/`busy_out` go 0 asynchronously; after release `byte_ready_out`=1 and the next byte 0xA5 is sent correctly.

Source files
------------

// File: rtl/serial_tx_pkg.sv
// Shared types and default timing for the bit-serial byte transmitter.
package serial_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_RDY,
    PRE,
    STROBE,
    GAP
  } state_t;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_PRE   = 10;
  localparam int unsigned DEF_HOLD  = 10;
  localparam int unsigned DEF_GAP   = 10;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/serial_byte_tx.sv
// Serializes one parallel word at a time, LSB first, as data/strobe pairs
// timed for the downstream deserializer; gated by a fresh status-high period.
module serial_byte_tx
  import serial_tx_pkg::*;
#(
  parameter int unsigned WIDTH       = DEF_WIDTH,
  parameter int unsigned PRE_CYCLES  = DEF_PRE,
  parameter int unsigned HOLD_CYCLES = DEF_HOLD,
  parameter int unsigned GAP_CYCLES  = DEF_GAP
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] byte_in,
  input  logic             byte_valid_in,
  output logic             byte_ready_out,
  input  logic             status_in,
  output logic             data_out,
  output logic             write_out,
  output logic             busy_out,
  output logic             done_out
);

  localparam int unsigned CNT_W = $clog2(max3(PRE_CYCLES, HOLD_CYCLES, GAP_CYCLES) + 1);
  localparam int unsigned BIT_W = $clog2(WIDTH + 1);

  if (WIDTH == 0 || PRE_CYCLES == 0 || HOLD_CYCLES == 0 || GAP_CYCLES == 0) begin : g_bad_param
    $error("serial_byte_tx: WIDTH, PRE_CYCLES, HOLD_CYCLES and GAP_CYCLES must be non-zero");
  end

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BIT_W-1:0] bits_q, bits_d;
  logic [WIDTH-1:0] shift_q, shift_d, shift_nxt;
  logic             armed_q, armed_d;
  logic             ready_d, data_d, write_d, busy_d, done_d;
  logic             accept, cnt_zero, last_bit, start;

  assign accept    = (state_q == IDLE) && byte_valid_in && byte_ready_out;
  assign start     = status_in && armed_q;
  assign cnt_zero  = (cnt_q == '0);
  assign last_bit  = (bits_q == BIT_W'(WIDTH));
  assign shift_nxt = shift_q >> 1;

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (accept)   state_d = WAIT_RDY;
      WAIT_RDY: if (start)    state_d = PRE;
      PRE:      if (cnt_zero) state_d = STROBE;
      STROBE:   if (cnt_zero) state_d = GAP;
      GAP:      if (cnt_zero) state_d = last_bit ? IDLE : STROBE;
      default:                state_d = IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    cnt_d   = cnt_q;
    bits_d  = bits_q;
    shift_d = shift_q;
    data_d  = data_out;
    write_d = write_out;
    busy_d  = busy_out;
    done_d  = 1'b0;
    // Any low status re-arms, so a status still high from the last word cannot start the next
    armed_d = armed_q | ~status_in;
    // Ready only once IDLE has been held for a full cycle, so never in the done cycle
    ready_d = (state_q == IDLE) && (state_d == IDLE);
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          shift_d = byte_in;
          bits_d  = '0;
          busy_d  = 1'b1;
        end
      end
      WAIT_RDY: begin
        if (start) begin
          armed_d = 1'b0;
          data_d  = shift_q[0];
          cnt_d   = CNT_W'(PRE_CYCLES - 1);
        end
      end
      PRE: begin
        if (cnt_zero) begin
          write_d = 1'b1;
          cnt_d   = CNT_W'(HOLD_CYCLES - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      STROBE: begin
        if (cnt_zero) begin
          write_d = 1'b0;
          shift_d = shift_nxt;
          data_d  = shift_nxt[0];
          bits_d  = bits_q + BIT_W'(1);
          cnt_d   = CNT_W'(GAP_CYCLES - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt_zero) begin
          if (last_bit) begin
            done_d = 1'b1;
            busy_d = 1'b0;
          end else begin
            write_d = 1'b1;
            cnt_d   = CNT_W'(HOLD_CYCLES - 1);
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q          <= '0;
      bits_q         <= '0;
      shift_q        <= '0;
      armed_q        <= 1'b1;
      byte_ready_out <= 1'b0;
      data_out       <= 1'b0;
      write_out      <= 1'b0;
      busy_out       <= 1'b0;
      done_out       <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      bits_q         <= bits_d;
      shift_q        <= shift_d;
      armed_q        <= armed_d;
      byte_ready_out <= ready_d;
      data_out       <= data_d;
      write_out      <= write_d;
      busy_out       <= busy_d;
      done_out       <= done_d;
    end
  end

endmodule

// File: tb/tb_serial_byte_tx.sv
// Directed bench for serial_byte_tx: bit order, strobe timing, re-arm, hold-off and async reset.
module tb_serial_byte_tx;
  import serial_tx_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] byte_in;
  logic       byte_valid_in;
  logic       byte_ready_out;
  logic       status_in;
  logic       data_out;
  logic       write_out;
  logic       busy_out;
  logic       done_out;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  logic [7:0] got_bits;
  int         n_strobes, bad_len, done_at, unstable, ready_hi, wr_cnt;

  serial_byte_tx #(
    .WIDTH(DEF_WIDTH), .PRE_CYCLES(DEF_PRE), .HOLD_CYCLES(DEF_HOLD), .GAP_CYCLES(DEF_GAP)
  ) dut (
    .clock(clock), .reset(reset), .byte_in(byte_in), .byte_valid_in(byte_valid_in),
    .byte_ready_out(byte_ready_out), .status_in(status_in), .data_out(data_out),
    .write_out(write_out), .busy_out(busy_out), .done_out(done_out)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Samples each negedge starting the cycle after PRE entry until done_out (index 170 expected).
  task automatic watch_word(input int drop_after, output logic [7:0] bits, output int nstr,
                            output int badlen, output int done_idx, output int unstab,
                            output int rdy_hi);
    logic prev_w, cur_d;
    int   len;
    bits = '0; nstr = 0; badlen = 0; done_idx = -1; unstab = 0; rdy_hi = 0;
    prev_w = 1'b0; cur_d = 1'b0; len = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      if (write_out && !prev_w) begin
        if (nstr < 8) bits[nstr[2:0]] = data_out;
        cur_d = data_out;
        nstr++;
        len = 0;
      end
      if (write_out) begin
        len++;
        if (data_out !== cur_d) unstab++;
      end
      if (!write_out && prev_w) begin
        if (len != int'(DEF_HOLD)) badlen++;
        if (drop_after >= 0 && nstr == drop_after + 1) status_in = 1'b0;
      end
      if (byte_ready_out) rdy_hi++;
      prev_w = write_out;
      if (done_out) begin
        done_idx = i;
        break;
      end
    end
  endtask

  initial begin
    reset = 1'b1; byte_in = 8'h00; byte_valid_in = 1'b0; status_in = 1'b0;

    // Reset state
    repeat (3) @(negedge clock);
    check("rst_ready", 32'(byte_ready_out), 0);
    check("rst_data",  32'(data_out), 0);
    check("rst_write", 32'(write_out), 0);
    check("rst_busy",  32'(busy_out), 0);
    check("rst_done",  32'(done_out), 0);
    reset = 1'b0;
    status_in = 1'b1;
    @(negedge clock);
    check("ready_after_rst", 32'(byte_ready_out), 1);

    // 0x99 with status already high
    byte_in = 8'h99; byte_valid_in = 1'b1;
    @(negedge clock);
    byte_valid_in = 1'b0;
    check("w99_busy",  32'(busy_out), 1);
    check("w99_ready", 32'(byte_ready_out), 0);
    watch_word(-1, got_bits, n_strobes, bad_len, done_at, unstable, ready_hi);
    check("w99_bits",     32'(got_bits), 32'h99);
    check("w99_nstrobe",  32'(n_strobes), 8);
    check("w99_len",      32'(bad_len), 0);
    check("w99_done_at",  32'(done_at), 170);
    check("w99_stable",   32'(unstable), 0);
    check("w99_busy_end", 32'(busy_out), 0);
    check("w99_rdy_done", 32'(byte_ready_out), 0);
    @(negedge clock);
    check("w99_done_pulse", 32'(done_out), 0);
    check("w99_rdy_after",  32'(byte_ready_out), 1);

    // 0xF0 while status stays high: must wait for a fresh status period
    byte_in = 8'hF0; byte_valid_in = 1'b1;
    @(negedge clock);
    byte_valid_in = 1'b0;
    check("wF0_busy", 32'(busy_out), 1);
    wr_cnt = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (write_out) wr_cnt++;
    end
    check("wF0_no_rearm", 32'(wr_cnt), 0);
    status_in = 1'b0;
    wr_cnt = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (write_out) wr_cnt++;
    end
    check("wF0_status_low", 32'(wr_cnt), 0);
    check("wF0_busy_wait",  32'(busy_out), 1);
    status_in = 1'b1;
    watch_word(-1, got_bits, n_strobes, bad_len, done_at, unstable, ready_hi);
    check("wF0_bits",    32'(got_bits), 32'hF0);
    check("wF0_done_at", 32'(done_at), 170);

    // 0x3C sent while producer holds 0x55 valid
    status_in = 1'b0;
    @(negedge clock);
    check("w3C_ready", 32'(byte_ready_out), 1);
    byte_in = 8'h3C; byte_valid_in = 1'b1;
    @(negedge clock);
    byte_in = 8'h55;
    status_in = 1'b1;
    watch_word(-1, got_bits, n_strobes, bad_len, done_at, unstable, ready_hi);
    check("w3C_bits",      32'(got_bits), 32'h3C);
    check("w3C_ready_hi",  32'(ready_hi), 0);
    check("w3C_done_at",   32'(done_at), 170);
    @(negedge clock);
    check("w55_ready_after", 32'(byte_ready_out), 1);
    @(negedge clock);
    byte_valid_in = 1'b0;
    check("w55_accepted", 32'(busy_out), 1);
    status_in = 1'b0;
    @(negedge clock);
    status_in = 1'b1;
    // Status dropped after bit 3 is ignored
    watch_word(3, got_bits, n_strobes, bad_len, done_at, unstable, ready_hi);
    check("w55_bits",    32'(got_bits), 32'h55);
    check("w55_nstrobe", 32'(n_strobes), 8);
    check("w55_done_at", 32'(done_at), 170);
    check("w55_status",  32'(status_in), 0);

    // Async reset during the bit-5 strobe of 0xE7
    @(negedge clock);
    byte_in = 8'hE7; byte_valid_in = 1'b1;
    @(negedge clock);
    byte_valid_in = 1'b0;
    status_in = 1'b1;
    for (int i = 0; i < 114; i++) @(negedge clock);
    check("wE7_mid_write", 32'(write_out), 1);
    check("wE7_mid_bit5",  32'(data_out), 1);
    reset = 1'b1;
    #1;
    check("arst_write", 32'(write_out), 0);
    check("arst_data",  32'(data_out), 0);
    check("arst_busy",  32'(busy_out), 0);
    check("arst_ready", 32'(byte_ready_out), 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("arst_ready_after", 32'(byte_ready_out), 1);
    byte_in = 8'hA5; byte_valid_in = 1'b1;
    @(negedge clock);
    byte_valid_in = 1'b0;
    watch_word(-1, got_bits, n_strobes, bad_len, done_at, unstable, ready_hi);
    check("wA5_bits",    32'(got_bits), 32'hA5);
    check("wA5_nstrobe", 32'(n_strobes), 8);
    check("wA5_done_at", 32'(done_at), 170);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
